axi4_traffic_gen: RTL

Parametrised AXI4 master traffic generator and self-checker. It is the successor to the single-beat fixed-pattern master device used in the network benches. Each run issues one INCR write burst and/or one INCR read burst of programmable length through the `axi_interface` master side of a network endpoint. Write data follows an additive pattern and read data is checked against the same pattern, so a bench only has to read `done` and `err_count`.

---
 rtl/axi4_traffic_gen.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_traffic_gen.sv
// axi4_traffic_gen: AXI4 master that issues one INCR write burst and/or one INCR
// read burst. Write data is seed+k per beat; read data is checked against the
// same pattern.
// Optional feature macro: AXI4_TRAFFIC_GEN_CHECK_EN builds the response
// comparators and the saturating err_count register. Without it err_count is 0.
module axi4_traffic_gen #(
  parameter int unsigned ID         = 0,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start_write,
  input  logic                      start_read,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [LW-1:0]             len,
  input  logic [DATA_WIDTH-1:0]     seed,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               err_count,
  // AW channel
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ID_WIDTH-1:0]       awid,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  // W channel
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  // B channel
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  input  logic [ID_WIDTH-1:0]       bid,
  // AR channel
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ID_WIDTH-1:0]       arid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  // R channel
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic [ID_WIDTH-1:0]       rid,
  input  logic                      rlast
);

  localparam logic [2:0]          AxSize    = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0]          BurstIncr = 2'b01;
  localparam logic [1:0]          RespOkay  = 2'b00;
  localparam logic [ID_WIDTH-1:0] IdVal     = ID_WIDTH'(ID);
  localparam logic [LW-1:0]       MaxLen    = LW'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StFin} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic [DATA_WIDTH-1:0]   data_q;    // pattern value for the current beat
  logic [7:0]              len_m1_q;  // burst length minus one (AxLEN encoding)
  logic [7:0]              beat_q;
  logic                    do_read_q;

  logic                    start_any;
  logic [LW-1:0]           len_clip;
  logic [7:0]              len_m1;
  logic                    last_beat;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    r_exit;

  assign start_any = start_write | start_read;
  assign last_beat = (beat_q == len_m1_q);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // Clamp the requested length into 1..MAX_LEN beats
  always_comb begin
    len_clip = len;
    if (len == '0) begin
      len_clip = LW'(1);
    end else if (len > MaxLen) begin
      len_clip = MaxLen;
    end
    len_m1 = 8'(len_clip - LW'(1));
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_write) begin
          state_d = StAw;
        end else if (start_read) begin
          state_d = StAr;
        end
      end
      StAw:  if (aw_hs) state_d = StW;
      StW:   if (w_hs && last_beat) state_d = StB;
      StB:   if (b_hs) state_d = do_read_q ? StAr : StFin;
      StAr:  if (ar_hs) state_d = StR;
      StR:   if (r_hs && r_exit) state_d = StFin;
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: valids/readies and status follow the registered state
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      StIdle: busy    = 1'b0;
      StAw:   awvalid = 1'b1;
      StW:    wvalid  = 1'b1;
      StB:    bready  = 1'b1;
      StAr:   arvalid = 1'b1;
      StR:    rready  = 1'b1;
      StFin:  done    = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // Payloads are forced to zero whenever their channel is not valid
  assign awid    = awvalid ? IdVal     : '0;
  assign awaddr  = awvalid ? addr_q    : '0;
  assign awlen   = awvalid ? len_m1_q  : '0;
  assign awsize  = awvalid ? AxSize    : '0;
  assign awburst = awvalid ? BurstIncr : '0;
  assign arid    = arvalid ? IdVal     : '0;
  assign araddr  = arvalid ? addr_q    : '0;
  assign arlen   = arvalid ? len_m1_q  : '0;
  assign arsize  = arvalid ? AxSize    : '0;
  assign arburst = arvalid ? BurstIncr : '0;
  assign wdata   = wvalid  ? data_q    : '0;
  assign wstrb   = wvalid  ? '1        : '0;
  assign wlast   = wvalid & last_beat;

  // Burst parameters, beat counter and running pattern value
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      seed_q    <= '0;
      data_q    <= '0;
      len_m1_q  <= '0;
      beat_q    <= '0;
      do_read_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start_any) begin
        addr_q    <= addr;
        seed_q    <= seed;
        data_q    <= seed;
        len_m1_q  <= len_m1;
        beat_q    <= '0;
        do_read_q <= start_read;
      end
      // Each burst restarts the pattern from the seed
      if (aw_hs || ar_hs) begin
        data_q <= seed_q;
        beat_q <= '0;
      end
      if (w_hs || r_hs) begin
        data_q <= data_q + DATA_WIDTH'(1);
        beat_q <= beat_q + 8'd1;
      end
    end
  end

`ifdef AXI4_TRAFFIC_GEN_CHECK_EN
  logic        b_err, r_err;
  logic [15:0] err_q;

  assign b_err  = (bresp != RespOkay) || (bid != IdVal);
  assign r_err  = (rdata != data_q) || (rresp != RespOkay) || (rid != IdVal) ||
                  (rlast != last_beat);
  // An early rlast terminates the read burst
  assign r_exit = last_beat | rlast;

  // Saturating count, at most one per failing handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= '0;
    end else if (((b_hs && b_err) || (r_hs && r_err)) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  logic unused_rsp;

  assign r_exit     = last_beat;
  assign err_count  = '0;
  assign unused_rsp = ^{bresp, bid, rdata, rresp, rid, rlast};
`endif

endmodule
